// File: rtl/deserializer_1to10_pkg.sv
// Shared TMDS deserializer definitions: control-token symbols and alignment FSM states.
package deserializer_1to10_pkg;

   localparam int unsigned SYM_W = 10;
   localparam int unsigned CNT_W = 4;

   // DVI control tokens, symbol bit 0 is transmitted first
   localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } des_state_t;

endpackage

// File: rtl/tmds_token_detect.sv
// Combinational TMDS control-token recogniser: flags a token symbol and decodes {C1,C0}.
module tmds_token_detect
   import deserializer_1to10_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic             token_c,
   output logic [1:0]       ctrl_c
);

   // Exact compare against the four control tokens; anything else is data
   always_comb begin
      token_c = 1'b0;
      ctrl_c  = 2'b00;
      case (sym)
         CTRL_00: begin token_c = 1'b1; ctrl_c = 2'b00; end
         CTRL_01: begin token_c = 1'b1; ctrl_c = 2'b01; end
         CTRL_10: begin token_c = 1'b1; ctrl_c = 2'b10; end
         CTRL_11: begin token_c = 1'b1; ctrl_c = 2'b11; end
         default: begin token_c = 1'b0; ctrl_c = 2'b00; end
      endcase
   end

endmodule

// File: rtl/deserializer_1to10.sv
// 1:10 TMDS deserializer with bit-slip word alignment locked on DVI control tokens.
module deserializer_1to10
   import deserializer_1to10_pkg::*;
#(
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned SEARCH_WORDS  = 16,
   parameter int unsigned TIMEOUT_WORDS = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_serial,
   output logic [SYM_W-1:0] o_data,
   output logic             o_valid,
   output logic             o_token,
   output logic [1:0]       o_ctrl,
   output logic             o_locked,
   output logic             o_slip
);

   localparam int unsigned MISS_MAX = (SEARCH_WORDS > TIMEOUT_WORDS) ? SEARCH_WORDS : TIMEOUT_WORDS;
   localparam int unsigned MISS_W   = $clog2(MISS_MAX + 1);
   localparam int unsigned TOK_W    = $clog2(LOCK_COUNT + 1);

   // Only the upper nine history bits are ever reused, so bit 0 is not stored
   logic [SYM_W-2:0] sr;
   logic [CNT_W-1:0] cnt;
   logic [TOK_W-1:0] tok_cnt;
   logic [MISS_W-1:0] miss_cnt;
   des_state_t       state;

   logic [SYM_W-1:0] word_c;
   logic             word_end_c;
   logic             tok_c;
   logic [1:0]       ctrl_c;

   assign word_c     = {i_serial, sr};
   assign word_end_c = (cnt == CNT_W'(SYM_W - 1));

   tmds_token_detect u_detect (
      .sym     (word_c),
      .token_c (tok_c),
      .ctrl_c  (ctrl_c)
   );

   // Shift, word framing, counters and SEARCH/LOCKED alignment FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sr       <= '0;
         cnt      <= '0;
         tok_cnt  <= '0;
         miss_cnt <= '0;
         state    <= SEARCH;
         o_data   <= '0;
         o_valid  <= 1'b0;
         o_token  <= 1'b0;
         o_ctrl   <= 2'b00;
         o_locked <= 1'b0;
         o_slip   <= 1'b0;
      end else begin
         sr      <= word_c[SYM_W-1:1];
         o_valid <= 1'b0;
         o_slip  <= 1'b0;

         // o_slip marks the hold cycle: bit counter stays at 0 one extra clock
         if (o_slip || word_end_c) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         if (word_end_c) begin
            o_data  <= word_c;
            o_valid <= 1'b1;
            o_token <= tok_c;
            o_ctrl  <= ctrl_c;

            case (state)
               SEARCH: begin
                  if (tok_c) begin
                     miss_cnt <= '0;
                     if (32'(tok_cnt) + 32'd1 >= LOCK_COUNT) begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                        tok_cnt  <= '0;
                     end else begin
                        tok_cnt <= tok_cnt + TOK_W'(1);
                     end
                  end else begin
                     tok_cnt <= '0;
                     if (32'(miss_cnt) + 32'd1 >= SEARCH_WORDS) begin
                        miss_cnt <= '0;
                        o_slip   <= 1'b1;
                     end else begin
                        miss_cnt <= miss_cnt + MISS_W'(1);
                     end
                  end
               end
               LOCKED: begin
                  if (tok_c) begin
                     miss_cnt <= '0;
                  end else if (32'(miss_cnt) + 32'd1 >= TIMEOUT_WORDS) begin
                     state    <= SEARCH;
                     o_locked <= 1'b0;
                     miss_cnt <= '0;
                     tok_cnt  <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + MISS_W'(1);
                  end
               end
               default: begin
                  state    <= SEARCH;
                  o_locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_deserializer_1to10.sv
// Directed self-checking bench for the 1:10 TMDS deserializer.
module tb_deserializer_1to10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ser;
   logic [9:0] o_data;
   logic       o_valid;
   logic       o_token;
   logic [1:0] o_ctrl;
   logic       o_locked;
   logic       o_slip;

   int checks = 0;
   int errors = 0;
   int bits   = 0;
   int slips  = 0;

   localparam logic [9:0] T_C00  = 10'b1101010100;
   localparam logic [9:0] T_C01  = 10'b0010101011;
   localparam logic [9:0] T_C10  = 10'b0101010100;
   localparam logic [9:0] T_C11  = 10'b1010101011;
   localparam logic [9:0] T_DATA = 10'b0110100110;
   localparam logic [9:0] T_ROT3 = 10'b1001101010;

   deserializer_1to10 #(
      .LOCK_COUNT    (4),
      .SEARCH_WORDS  (8),
      .TIMEOUT_WORDS (16)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_serial (ser),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .o_token  (o_token),
      .o_ctrl   (o_ctrl),
      .o_locked (o_locked),
      .o_slip   (o_slip)
   );

   always #5 clk = ~clk;

   task automatic send_bit(input logic b);
      ser = b;
      @(posedge clk);
      #1;
      bits++;
      if (o_slip) slips++;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ser   = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bits  = 0;
      slips = 0;
   endtask

   task automatic lock_c0();
      for (int w = 0; w < 4; w++) send_word(T_C00);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ser   = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if ({o_data, o_valid, o_token, o_ctrl, o_locked, o_slip} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs got data=%b v=%b t=%b c=%b l=%b s=%b exp all zero",
                  o_data, o_valid, o_token, o_ctrl, o_locked, o_slip);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bits  = 0;
      slips = 0;
   endtask

   task automatic test_aligned_lock();
      for (int w = 1; w <= 4; w++) begin
         for (int i = 0; i < 9; i++) send_bit(T_C00[i]);
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL aligned_early_valid word %0d got %b exp 0", w, o_valid);
         end
         send_bit(T_C00[9]);
         checks++;
         if (o_valid !== 1'b1 || o_data !== T_C00 || o_token !== 1'b1 || o_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL aligned_word %0d got v=%b d=%b t=%b c=%b exp v=1 d=%b t=1 c=00",
                     w, o_valid, o_data, o_token, o_ctrl, T_C00);
         end
         checks++;
         if (o_locked !== (w == 4)) begin
            errors++;
            $display("FAIL aligned_locked word %0d got %b exp %b", w, o_locked, (w == 4));
         end
      end
      checks++;
      if (slips !== 0) begin
         errors++;
         $display("FAIL aligned_no_slip got %0d exp 0", slips);
      end
   endtask

   task automatic test_slip_search();
      logic [9:0] c0 = T_C00;
      int slip_n    = 0;
      int last_slip = 0;
      int lock_bit  = 0;
      bit first     = 1'b1;
      do_reset();
      for (int k = 0; k < 1500 && lock_bit == 0; k++) begin
         send_bit(c0[(k + 3) % 10]);
         if (o_valid && first) begin
            first = 1'b0;
            checks++;
            if (o_data !== T_ROT3) begin
               errors++;
               $display("FAIL slip_first_word got %b exp %b", o_data, T_ROT3);
            end
         end
         if (o_slip) begin
            slip_n++;
            checks++;
            if ((slip_n == 1 && bits != 80) || (slip_n > 1 && bits - last_slip != 81)) begin
               errors++;
               $display("FAIL slip_spacing slip %0d at bit %0d prev %0d exp 80 then 81 apart",
                        slip_n, bits, last_slip);
            end
            last_slip = bits;
         end
         if (o_locked) lock_bit = bits;
      end
      checks++;
      if (lock_bit == 0) begin
         errors++;
         $display("FAIL slip_lock_timeout got locked=%b exp 1 within 1500 bits", o_locked);
      end
      checks++;
      if (slip_n != 7) begin
         errors++;
         $display("FAIL slip_count got %0d exp 7", slip_n);
      end
      checks++;
      if (lock_bit - last_slip != 41) begin
         errors++;
         $display("FAIL slip_lock_delay got %0d bits exp 41", lock_bit - last_slip);
      end
      checks++;
      if (o_data !== T_C00 || o_ctrl !== 2'b00 || o_token !== 1'b1) begin
         errors++;
         $display("FAIL slip_lock_word got d=%b c=%b t=%b exp d=%b c=00 t=1",
                  o_data, o_ctrl, o_token, T_C00);
      end
   endtask

   task automatic test_timeout();
      int s0;
      do_reset();
      lock_c0();
      s0 = slips;
      for (int w = 1; w <= 16; w++) begin
         send_word(T_DATA);
         if (w == 1) begin
            checks++;
            if (o_data !== T_DATA || o_token !== 1'b0 || o_ctrl !== 2'b00) begin
               errors++;
               $display("FAIL timeout_data_word got d=%b t=%b c=%b exp d=%b t=0 c=00",
                        o_data, o_token, o_ctrl, T_DATA);
            end
         end
         checks++;
         if (o_locked !== (w < 16)) begin
            errors++;
            $display("FAIL timeout_locked word %0d got %b exp %b", w, o_locked, (w < 16));
         end
      end
      checks++;
      if (slips != s0) begin
         errors++;
         $display("FAIL timeout_slip_while_locked got %0d exp 0", slips - s0);
      end
      for (int w = 1; w <= 8; w++) begin
         send_word(T_DATA);
         checks++;
         if (o_slip !== (w == 8)) begin
            errors++;
            $display("FAIL timeout_resume_slip word %0d got %b exp %b", w, o_slip, (w == 8));
         end
      end
   endtask

   task automatic test_sparse_tokens();
      logic [9:0] toks [4];
      toks[0] = T_C00;
      toks[1] = T_C01;
      toks[2] = T_C10;
      toks[3] = T_C11;
      do_reset();
      lock_c0();
      for (int r = 0; r < 4; r++) begin
         send_word(toks[r]);
         checks++;
         if (o_valid !== 1'b1 || o_token !== 1'b1 || o_ctrl !== 2'(r)) begin
            errors++;
            $display("FAIL sparse_token %0d got v=%b t=%b c=%b exp v=1 t=1 c=%b",
                     r, o_valid, o_token, o_ctrl, 2'(r));
         end
         for (int j = 0; j < 9; j++) begin
            send_word(T_DATA);
            checks++;
            if (o_token !== 1'b0 || o_ctrl !== 2'b00) begin
               errors++;
               $display("FAIL sparse_data round %0d word %0d got t=%b c=%b exp t=0 c=00",
                        r, j, o_token, o_ctrl);
            end
         end
         checks++;
         if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL sparse_locked round %0d got %b exp 1", r, o_locked);
         end
      end
   endtask

   task automatic test_broken_run();
      do_reset();
      for (int w = 0; w < 3; w++) send_word(T_C00);
      checks++;
      if (o_locked !== 1'b0) begin
         errors++;
         $display("FAIL broken_after3 got %b exp 0", o_locked);
      end
      send_word(T_DATA);
      for (int w = 1; w <= 4; w++) begin
         send_word(T_C00);
         checks++;
         if (o_locked !== (w == 4)) begin
            errors++;
            $display("FAIL broken_second_run token %0d got %b exp %b", w, o_locked, (w == 4));
         end
      end
   endtask

   task automatic test_async_reset();
      bit early = 1'b0;
      do_reset();
      lock_c0();
      for (int i = 0; i < 5; i++) send_bit(T_C00[i]);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_data, o_valid, o_token, o_ctrl, o_locked, o_slip} !== 16'h0) begin
         errors++;
         $display("FAIL async_reset got data=%b v=%b t=%b c=%b l=%b s=%b exp all zero",
                  o_data, o_valid, o_token, o_ctrl, o_locked, o_slip);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         send_bit(T_C00[i]);
         if (o_valid) early = 1'b1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL async_early_valid got 1 exp 0 before 10th bit");
      end
      send_bit(T_C00[9]);
      checks++;
      if (o_valid !== 1'b1 || o_data !== T_C00 || o_locked !== 1'b0) begin
         errors++;
         $display("FAIL async_first_word got v=%b d=%b l=%b exp v=1 d=%b l=0",
                  o_valid, o_data, o_locked, T_C00);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ser   = 1'b0;
      test_reset();
      test_aligned_lock();
      test_slip_search();
      test_timeout();
      test_sparse_tokens();
      test_broken_run();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
